// File: rtl/decap_ekey_lookup.sv
// Two-table cuckoo-style key lookup: reads one bucket from each hash table, picks the first
// matching entry, then fetches its value record. Optional wait watchdog via EKEY_LOOKUP_TIMEOUT_EN.
`timescale 1ns/1ps

`ifndef EKEY_HASH_TABLE_DEPTH_NBITS
`define EKEY_HASH_TABLE_DEPTH_NBITS 10
`endif
`ifndef EKEY_VALUE_DEPTH_NBITS
`define EKEY_VALUE_DEPTH_NBITS 8
`endif
`ifndef EKEY_VALUE_NBITS
`define EKEY_VALUE_NBITS 32
`endif
`ifndef RESET_SIG
`define RESET_SIG srst
`endif

module decap_ekey_lookup #(
    parameter int DEPTH_NBITS       = `EKEY_HASH_TABLE_DEPTH_NBITS,
    parameter int TAG_NBITS         = 16,
    parameter int VALUE_DEPTH_NBITS = `EKEY_VALUE_DEPTH_NBITS,
    parameter int VALUE_NBITS       = `EKEY_VALUE_NBITS,
    parameter int BUCKET_NBITS      = 2*(1+TAG_NBITS+VALUE_DEPTH_NBITS)
) (
    input  logic                         clk,
    input  logic                         `RESET_SIG,

    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [DEPTH_NBITS-1:0]       req_hash0,
    input  logic [DEPTH_NBITS-1:0]       req_hash1,
    input  logic [TAG_NBITS-1:0]         req_tag,

    output logic                         ekey_hash_table0_rd,
    output logic [DEPTH_NBITS-1:0]       ekey_hash_table0_raddr,
    input  logic                         ekey_hash_table0_ack,
    input  logic [BUCKET_NBITS-1:0]      ekey_hash_table0_rdata,

    output logic                         ekey_hash_table1_rd,
    output logic [DEPTH_NBITS-1:0]       ekey_hash_table1_raddr,
    input  logic                         ekey_hash_table1_ack,
    input  logic [BUCKET_NBITS-1:0]      ekey_hash_table1_rdata,

    output logic                         ekey_value_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] ekey_value_raddr,
    input  logic                         ekey_value_ack,
    input  logic [VALUE_NBITS-1:0]       ekey_value_rdata,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_hit,
    output logic                         rsp_err,
    output logic [VALUE_NBITS-1:0]       rsp_value
);

    localparam int ENTRY_NBITS = 1 + TAG_NBITS + VALUE_DEPTH_NBITS;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HT_RD    = 3'd1,
        HT_WAIT  = 3'd2,
        VAL_RD   = 3'd3,
        VAL_WAIT = 3'd4,
        RESP     = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    logic [DEPTH_NBITS-1:0]         hash0_q, hash0_d;
    logic [DEPTH_NBITS-1:0]         hash1_q, hash1_d;
    logic [TAG_NBITS-1:0]           tag_q, tag_d;
    logic                           cap0_q, cap0_d;
    logic                           cap1_q, cap1_d;
    logic [BUCKET_NBITS-1:0]        bucket0_q, bucket0_d;
    logic [BUCKET_NBITS-1:0]        bucket1_q, bucket1_d;
    logic [VALUE_DEPTH_NBITS-1:0]   ptr_q, ptr_d;
    logic                           rsp_hit_q, rsp_hit_d;
    logic [VALUE_NBITS-1:0]         rsp_value_q, rsp_value_d;

    logic                           wd_expired;
    logic                           tables_done;
    logic [BUCKET_NBITS-1:0]        eff_bucket0, eff_bucket1;
    logic [3:0]                     ent_match;
    logic [VALUE_DEPTH_NBITS-1:0]   ent_ptr [4];
    logic                           any_match;
    logic [VALUE_DEPTH_NBITS-1:0]   hit_ptr;

    // A bucket arriving this cycle is used directly so the match decision costs no extra cycle.
    assign eff_bucket0 = cap0_q ? bucket0_q : ekey_hash_table0_rdata;
    assign eff_bucket1 = cap1_q ? bucket1_q : ekey_hash_table1_rdata;
    assign tables_done = (cap0_q | ekey_hash_table0_ack) & (cap1_q | ekey_hash_table1_ack);

    // Entry index gi: table gi/2, slot gi%2, which is also the match priority order.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_entry
            logic [BUCKET_NBITS-1:0] bucket;
            logic [ENTRY_NBITS-1:0]  entry;
            assign bucket         = (gi < 2) ? eff_bucket0 : eff_bucket1;
            assign entry          = bucket[(gi % 2)*ENTRY_NBITS +: ENTRY_NBITS];
            assign ent_match[gi]  = entry[ENTRY_NBITS-1] &&
                                    (entry[ENTRY_NBITS-2 -: TAG_NBITS] == tag_q);
            assign ent_ptr[gi]    = entry[VALUE_DEPTH_NBITS-1:0];
        end
    endgenerate

    always_comb begin
        any_match = 1'b0;
        hit_ptr   = '0;
        for (int i = 3; i >= 0; i--) begin
            if (ent_match[i]) begin
                any_match = 1'b1;
                hit_ptr   = ent_ptr[i];
            end
        end
    end

`ifdef EKEY_LOOKUP_TIMEOUT_EN
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       rsp_err_q, rsp_err_d;

    // Firing at 254 means the counter would reach 255 on this edge, the last waiting cycle.
    assign wd_expired = (wd_cnt_q == 8'd254);
    assign rsp_err    = rsp_err_q;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            HT_RD, VAL_RD: wd_cnt_d = '0;
            HT_WAIT: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                if (tables_done)     rsp_err_d = 1'b0;
                else if (wd_expired) rsp_err_d = 1'b1;
            end
            VAL_WAIT: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                if (ekey_value_ack)  rsp_err_d = 1'b0;
                else if (wd_expired) rsp_err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            wd_cnt_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (`RESET_SIG) begin
            state_q     <= IDLE;
            hash0_q     <= '0;
            hash1_q     <= '0;
            tag_q       <= '0;
            cap0_q      <= 1'b0;
            cap1_q      <= 1'b0;
            bucket0_q   <= '0;
            bucket1_q   <= '0;
            ptr_q       <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_value_q <= '0;
        end else begin
            state_q     <= state_d;
            hash0_q     <= hash0_d;
            hash1_q     <= hash1_d;
            tag_q       <= tag_d;
            cap0_q      <= cap0_d;
            cap1_q      <= cap1_d;
            bucket0_q   <= bucket0_d;
            bucket1_q   <= bucket1_d;
            ptr_q       <= ptr_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_value_q <= rsp_value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req_valid) state_d = HT_RD;
            HT_RD:    state_d = HT_WAIT;
            HT_WAIT: begin
                if (tables_done)     state_d = any_match ? VAL_RD : RESP;
                else if (wd_expired) state_d = RESP;
            end
            VAL_RD:   state_d = VAL_WAIT;
            VAL_WAIT: if (ekey_value_ack || wd_expired) state_d = RESP;
            RESP:     if (rsp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready           = (state_q == IDLE);
        ekey_hash_table0_rd = (state_q == HT_RD);
        ekey_hash_table1_rd = (state_q == HT_RD);
        ekey_value_rd       = (state_q == VAL_RD);
        rsp_valid           = (state_q == RESP);
    end

    assign ekey_hash_table0_raddr = hash0_q;
    assign ekey_hash_table1_raddr = hash1_q;
    assign ekey_value_raddr       = ptr_q;
    assign rsp_hit                = rsp_hit_q;
    assign rsp_value              = rsp_value_q;

    always_comb begin
        hash0_d     = hash0_q;
        hash1_d     = hash1_q;
        tag_d       = tag_q;
        cap0_d      = cap0_q;
        cap1_d      = cap1_q;
        bucket0_d   = bucket0_q;
        bucket1_d   = bucket1_q;
        ptr_d       = ptr_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_value_d = rsp_value_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    hash0_d = req_hash0;
                    hash1_d = req_hash1;
                    tag_d   = req_tag;
                    cap0_d  = 1'b0;
                    cap1_d  = 1'b0;
                end
            end
            HT_WAIT: begin
                if (ekey_hash_table0_ack && !cap0_q) begin
                    cap0_d    = 1'b1;
                    bucket0_d = ekey_hash_table0_rdata;
                end
                if (ekey_hash_table1_ack && !cap1_q) begin
                    cap1_d    = 1'b1;
                    bucket1_d = ekey_hash_table1_rdata;
                end
                if (tables_done) begin
                    if (any_match) begin
                        ptr_d = hit_ptr;
                    end else begin
                        rsp_hit_d   = 1'b0;
                        rsp_value_d = '0;
                    end
                end else if (wd_expired) begin
                    rsp_hit_d   = 1'b0;
                    rsp_value_d = '0;
                end
            end
            VAL_WAIT: begin
                if (ekey_value_ack) begin
                    rsp_hit_d   = 1'b1;
                    rsp_value_d = ekey_value_rdata;
                end else if (wd_expired) begin
                    rsp_hit_d   = 1'b0;
                    rsp_value_d = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_decap_ekey_lookup.sv
// Randomized and directed bench for decap_ekey_lookup with behavioural table/value memories.
`timescale 1ns/1ps

`ifndef RESET_SIG
`define RESET_SIG srst
`endif

module tb_decap_ekey_lookup;
    localparam int DN  = 4;
    localparam int TN  = 16;
    localparam int VDN = 6;
    localparam int VN  = 32;
    localparam int W   = 1 + TN + VDN;
    localparam int BN  = 2 * W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [DN-1:0]   req_hash0 = '0, req_hash1 = '0;
    logic [TN-1:0]   req_tag = '0;
    logic            ht0_rd, ht1_rd, val_rd;
    logic [DN-1:0]   ht0_raddr, ht1_raddr;
    logic            ht0_ack = 1'b0, ht1_ack = 1'b0, val_ack = 1'b0;
    logic [BN-1:0]   ht0_rdata = '0, ht1_rdata = '0;
    logic [VDN-1:0]  val_raddr;
    logic [VN-1:0]   val_rdata = '0;
    logic            rsp_valid, rsp_hit, rsp_err;
    logic            rsp_ready = 1'b0;
    logic [VN-1:0]   rsp_value;

    int total = 0;
    int bad   = 0;

    decap_ekey_lookup #(
        .DEPTH_NBITS(DN), .TAG_NBITS(TN), .VALUE_DEPTH_NBITS(VDN),
        .VALUE_NBITS(VN), .BUCKET_NBITS(BN)
    ) dut (
        .clk(clk), .`RESET_SIG(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_hash0(req_hash0), .req_hash1(req_hash1), .req_tag(req_tag),
        .ekey_hash_table0_rd(ht0_rd), .ekey_hash_table0_raddr(ht0_raddr),
        .ekey_hash_table0_ack(ht0_ack), .ekey_hash_table0_rdata(ht0_rdata),
        .ekey_hash_table1_rd(ht1_rd), .ekey_hash_table1_raddr(ht1_raddr),
        .ekey_hash_table1_ack(ht1_ack), .ekey_hash_table1_rdata(ht1_rdata),
        .ekey_value_rd(val_rd), .ekey_value_raddr(val_raddr),
        .ekey_value_ack(val_ack), .ekey_value_rdata(val_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_err(rsp_err), .rsp_value(rsp_value)
    );

    always #5 clk = ~clk;

    // Reference contents: [table][bucket][slot]
    bit             tv [2][16][2];
    logic [TN-1:0]  tt [2][16][2];
    logic [VDN-1:0] tp [2][16][2];
    logic [VN-1:0]  vmem [64];

    // Responder controls (written by the stimulus thread only)
    int d0 = 0, d1 = 0, dv = 0;
    bit en0 = 1'b1;
    bit stray = 1'b0;
    // Responder state and observation counters (written by the responder only)
    bit p0 = 0, p1 = 0, pv = 0;
    int c0 = 0, c1 = 0, cv = 0;
    logic [DN-1:0]  a0 = '0, a1 = '0;
    logic [VDN-1:0] av = '0, last_vaddr = '0;
    int rd0_cnt = 0, rd1_cnt = 0, vrd_cnt = 0;

    function automatic logic [BN-1:0] pack_bucket(input int t, input int h);
        logic [BN-1:0] b;
        b = '0;
        for (int e = 0; e < 2; e++) b[e*W +: W] = {tv[t][h][e], tt[t][h][e], tp[t][h][e]};
        return b;
    endfunction

    // Memories answer d cycles after the cycle their read strobe was seen.
    always @(negedge clk) begin
        ht0_ack = 1'b0;
        ht1_ack = 1'b0;
        val_ack = 1'b0;
        if (p0) begin
            if (c0 == 0) begin ht0_ack = 1'b1; ht0_rdata = pack_bucket(0, int'(a0)); p0 = 0; end
            else c0--;
        end
        if (p1) begin
            if (c1 == 0) begin ht1_ack = 1'b1; ht1_rdata = pack_bucket(1, int'(a1)); p1 = 0; end
            else c1--;
        end
        if (pv) begin
            if (cv == 0) begin val_ack = 1'b1; val_rdata = vmem[av]; pv = 0; end
            else cv--;
        end
        if (stray) begin
            ht0_ack = 1'b1; ht1_ack = 1'b1; val_ack = 1'b1;
            ht0_rdata = pack_bucket(0, 0); ht1_rdata = pack_bucket(1, 0); val_rdata = vmem[0];
        end
        if (ht0_rd) begin rd0_cnt++; if (en0) begin p0 = 1; c0 = d0; a0 = ht0_raddr; end end
        if (ht1_rd) begin rd1_cnt++; p1 = 1; c1 = d1; a1 = ht1_raddr; end
        if (val_rd) begin vrd_cnt++; last_vaddr = val_raddr; pv = 1; cv = dv; av = val_raddr; end
    end

    function automatic void model_lookup(input logic [DN-1:0] h0, input logic [DN-1:0] h1,
                                         input logic [TN-1:0] tag,
                                         output bit hit, output logic [VDN-1:0] ptr);
        hit = 0;
        ptr = '0;
        for (int t = 0; t < 2; t++) begin
            for (int e = 0; e < 2; e++) begin
                int h;
                h = (t == 0) ? int'(h0) : int'(h1);
                if (!hit && tv[t][h][e] && tt[t][h][e] == tag) begin
                    hit = 1;
                    ptr = tp[t][h][e];
                end
            end
        end
    endfunction

    task automatic clear_tables();
        for (int t = 0; t < 2; t++)
            for (int h = 0; h < 16; h++)
                for (int e = 0; e < 2; e++) begin
                    tv[t][h][e] = 0; tt[t][h][e] = '0; tp[t][h][e] = '0;
                end
        for (int i = 0; i < 64; i++) vmem[i] = $urandom;
    endtask

    task automatic set_entry(input int t, input int h, input int e, input bit v,
                             input logic [TN-1:0] tag, input logic [VDN-1:0] ptr);
        tv[t][h][e] = v; tt[t][h][e] = tag; tp[t][h][e] = ptr;
    endtask

    task automatic issue(input logic [DN-1:0] h0, input logic [DN-1:0] h1, input logic [TN-1:0] tag);
        @(posedge clk); #1;
        req_valid = 1'b1; req_hash0 = h0; req_hash1 = h1; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic handshake(input string name);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s.release got valid=%b ready=%b want valid=0 ready=1", name, rsp_valid, req_ready);
        end
    endtask

    // Full lookup with model-derived expectations; hold = cycles rsp_ready stays low.
    task automatic do_lookup(input string name, input logic [DN-1:0] h0, input logic [DN-1:0] h1,
                             input logic [TN-1:0] tag, input int hold);
        bit exp_hit;
        logic [VDN-1:0] exp_ptr;
        logic [VN-1:0] exp_val;
        int exp_lat, j, r0, r1, vr, busy_bad, stab_bad;
        bit got;
        model_lookup(h0, h1, tag, exp_hit, exp_ptr);
        exp_val = exp_hit ? vmem[exp_ptr] : '0;
        exp_lat = 2 + ((d0 > d1) ? d0 : d1) + (exp_hit ? 2 + dv : 0);
        r0 = rd0_cnt; r1 = rd1_cnt; vr = vrd_cnt;
        busy_bad = 0; got = 0; j = 0;
        issue(h0, h1, tag);
        while (j < 600) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin got = 1; break; end
            if (req_ready !== 1'b0) busy_bad++;
            j++;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s.timeout got no rsp_valid in 600 cycles want latency %0d", name, exp_lat);
            return;
        end
        $display("txn %s tag=%h h0=%0d h1=%0d hit=%b value=%h lat=%0d", name, tag, h0, h1, rsp_hit, rsp_value, j);
        if (j !== exp_lat) begin bad++; $display("FAIL %s.latency got=%0d want=%0d", name, j, exp_lat); end
        total++;
        if (rsp_hit !== exp_hit) begin bad++; $display("FAIL %s.hit got=%b want=%b", name, rsp_hit, exp_hit); end
        total++;
        if (rsp_value !== exp_val) begin bad++; $display("FAIL %s.value got=%h want=%h", name, rsp_value, exp_val); end
        total++;
        if (rsp_err !== 1'b0) begin bad++; $display("FAIL %s.err got=%b want=0", name, rsp_err); end
        total++;
        if (vrd_cnt - vr !== (exp_hit ? 1 : 0)) begin
            bad++; $display("FAIL %s.value_reads got=%0d want=%0d", name, vrd_cnt - vr, exp_hit ? 1 : 0);
        end
        total++;
        if (exp_hit && last_vaddr !== exp_ptr) begin
            bad++; $display("FAIL %s.value_raddr got=%0d want=%0d", name, last_vaddr, exp_ptr);
        end
        total++;
        if (rd0_cnt - r0 !== 1 || rd1_cnt - r1 !== 1) begin
            bad++; $display("FAIL %s.table_reads got=%0d/%0d want=1/1", name, rd0_cnt - r0, rd1_cnt - r1);
        end
        total++;
        if (busy_bad != 0) begin bad++; $display("FAIL %s.req_ready_busy got high %0d cycles want 0", name, busy_bad); end
        stab_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_hit !== exp_hit || rsp_value !== exp_val || req_ready !== 1'b0)
                stab_bad++;
        end
        total++;
        if (stab_bad != 0) begin bad++; $display("FAIL %s.hold_stable got %0d unstable cycles want 0", name, stab_bad); end
        handshake(name);
    endtask

    task automatic test_reset();
        int sbad;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_err !== 1'b0 || rsp_value !== '0) begin
            bad++;
            $display("FAIL reset.outputs got ready=%b valid=%b hit=%b err=%b value=%h want 1 0 0 0 0",
                     req_ready, rsp_valid, rsp_hit, rsp_err, rsp_value);
        end
        total++;
        if (ht0_rd !== 1'b0 || ht1_rd !== 1'b0 || val_rd !== 1'b0 ||
            ht0_raddr !== '0 || ht1_raddr !== '0 || val_raddr !== '0) begin
            bad++;
            $display("FAIL reset.mem_ports got rd=%b%b%b raddr=%0d/%0d/%0d want all 0",
                     ht0_rd, ht1_rd, val_rd, ht0_raddr, ht1_raddr, val_raddr);
        end
        // Acks while idle must not start anything.
        @(posedge clk); #1 stray = 1'b1;
        repeat (2) @(posedge clk);
        #1 stray = 1'b0;
        sbad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) sbad++;
        end
        total++;
        if (sbad != 0) begin bad++; $display("FAIL reset.stray_ack got %0d disturbed cycles want 0", sbad); end
        $display("txn reset_and_stray_acks done");
    endtask

    task automatic test_directed();
        clear_tables();
        d0 = 0; d1 = 0; dv = 0;
        set_entry(0, 2, 0, 1, 16'h1111, 6'd3);
        set_entry(0, 2, 1, 1, 16'h1234, 6'd5);
        set_entry(1, 6, 0, 1, 16'h1234, 6'd9);
        do_lookup("hit_1234", 4'd2, 4'd6, 16'h1234, 0);
        set_entry(0, 4, 0, 0, 16'hBEEF, 6'd2);
        do_lookup("miss_beef_invalid", 4'd4, 4'd7, 16'hBEEF, 0);
        do_lookup("miss_beef_absent", 4'd5, 4'd8, 16'hBEEF, 1);
    endtask

    task automatic test_priority();
        clear_tables();
        d0 = 0; d1 = 0; dv = 0;
        for (int e = 0; e < 4; e++) set_entry(e / 2, (e < 2) ? 9 : 10, e % 2, 1, 16'h7777, 6'(20 + e));
        for (int e = 0; e < 4; e++) begin
            do_lookup($sformatf("priority_%0d", e), 4'd9, 4'd10, 16'h7777, 0);
            tv[e / 2][(e < 2) ? 9 : 10][e % 2] = 0;
        end
    endtask

    task automatic test_ack_order_and_hold();
        clear_tables();
        set_entry(1, 3, 1, 1, 16'hA5A5, 6'd33);
        d0 = 3; d1 = 0; dv = 0;
        do_lookup("t1_first_hold10", 4'd1, 4'd3, 16'hA5A5, 10);
        d0 = 0; d1 = 2; dv = 1;
        do_lookup("t0_first_vdelay", 4'd1, 4'd3, 16'hA5A5, 2);
        d0 = 0; d1 = 0; dv = 0;
    endtask

    task automatic test_reset_in_val_wait();
        int sbad;
        clear_tables();
        set_entry(0, 3, 0, 1, 16'h4242, 6'd7);
        d0 = 0; d1 = 0; dv = 5;
        issue(4'd3, 4'd0, 16'h4242);
        repeat (4) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sbad = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) sbad++;
        end
        total++;
        if (sbad != 0) begin bad++; $display("FAIL rst_val_wait.idle got %0d bad cycles want 0", sbad); end
        $display("txn rst_val_wait abandoned");
        dv = 0;
        do_lookup("after_reset", 4'd3, 4'd0, 16'h4242, 0);
    endtask

    task automatic test_timeout();
        int j;
        bit got;
        clear_tables();
        d0 = 0; d1 = 0; dv = 0;
        en0 = 1'b0;
        issue(4'd1, 4'd2, 16'h0BAD);
        got = 0; j = 0;
`ifdef EKEY_LOOKUP_TIMEOUT_EN
        while (j < 600) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin got = 1; break; end
            j++;
        end
        total++;
        if (!got || j != 256) begin bad++; $display("FAIL timeout.latency got=%0d seen=%b want=256", j, got); end
        total++;
        if (rsp_err !== 1'b1 || rsp_hit !== 1'b0 || rsp_value !== '0) begin
            bad++; $display("FAIL timeout.fields got err=%b hit=%b value=%h want 1 0 0", rsp_err, rsp_hit, rsp_value);
        end
        $display("txn timeout err=%b lat=%0d", rsp_err, j);
        en0 = 1'b1;
        if (got) handshake("timeout");
`else
        while (j < 1000) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0) got = 1;
            j++;
        end
        total++;
        if (got) begin bad++; $display("FAIL no_timeout.waiting got early response or ready want still waiting"); end
        $display("txn no_timeout still waiting after %0d cycles", j);
        en0 = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL no_timeout.reset got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
`endif
    endtask

    task automatic test_random();
        logic [TN-1:0] pool [8];
        logic [TN-1:0] tag;
        for (int i = 0; i < 8; i++) pool[i] = 16'h1000 + 16'(i);
        clear_tables();
        for (int t = 0; t < 2; t++)
            for (int h = 0; h < 16; h++)
                for (int e = 0; e < 2; e++)
                    set_entry(t, h, e, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 6'($urandom));
        for (int n = 0; n < 24; n++) begin
            tag = ($urandom_range(0, 5) == 0) ? 16'hFFFF : pool[$urandom_range(0, 7)];
            d0 = $urandom_range(0, 3); d1 = $urandom_range(0, 3); dv = $urandom_range(0, 3);
            do_lookup($sformatf("rand_%0d", n), 4'($urandom), 4'($urandom), tag, $urandom_range(0, 3));
        end
        d0 = 0; d1 = 0; dv = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_priority();
        test_ack_order_and_hold();
        test_reset_in_val_wait();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog.sim got no finish want finish before 2ms");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
